// File: rtl/route_lookup_ctrl.sv
// Dual-port lookup controller sitting in front of the routing table.
// Each port takes a destination over valid/ready, drives it onto its table
// read port, captures the next-hop after the table's one-cycle registered
// read and returns it over valid/ready. Ports A and B share nothing.

module route_lookup_port #(
    parameter int ADDR_WIDTH = 8,
    parameter int NH_WIDTH   = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  config_done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] s_dest,
    output logic [ADDR_WIDTH-1:0] tbl_dest,
    input  logic [NH_WIDTH-1:0]   tbl_nexthop,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [NH_WIDTH-1:0]   m_nexthop,
    output logic [ADDR_WIDTH-1:0] m_dest,
    output logic [15:0]           lookups
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  done;
    logic [ADDR_WIDTH-1:0] dest_reg;
    logic [NH_WIDTH-1:0]   nexthop_reg;
    logic                  valid_reg;
    logic [15:0]           lookup_cnt;

    // Next-state decode; nothing advances while enable is low.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        s_ready    = (state == IDLE) && config_done && enable;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        accept     = 1'b1;
                        state_next = ISSUE;
                    end
                end
                ISSUE:   state_next = CAPTURE;
                CAPTURE: state_next = HOLD;
                HOLD: begin
                    if (m_ready) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register; reset discards any in-flight lookup.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address latch, next-hop capture, result valid and completion counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            dest_reg    <= '0;
            nexthop_reg <= '0;
            valid_reg   <= 1'b0;
            lookup_cnt  <= '0;
        end else begin
            if (accept) begin
                dest_reg <= s_dest;
            end
            // Table read data is valid during CAPTURE (one cycle after ISSUE).
            if (enable && (state == CAPTURE)) begin
                nexthop_reg <= tbl_nexthop;
                valid_reg   <= 1'b1;
            end
            if (done) begin
                valid_reg  <= 1'b0;
                lookup_cnt <= lookup_cnt + 16'd1;
            end
        end
    end

    // dest_reg only changes on acceptance, so the table address and the
    // echoed destination stay stable from ISSUE through HOLD.
    assign tbl_dest  = dest_reg;
    assign m_dest    = dest_reg;
    assign m_nexthop = nexthop_reg;
    assign m_valid   = valid_reg;
    assign lookups   = lookup_cnt;

endmodule

module route_lookup_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int NH_WIDTH   = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  config_done,
    input  logic                  a_s_valid,
    output logic                  a_s_ready,
    input  logic [ADDR_WIDTH-1:0] a_s_dest,
    output logic [ADDR_WIDTH-1:0] a_tbl_dest,
    input  logic [NH_WIDTH-1:0]   a_tbl_nexthop,
    output logic                  a_m_valid,
    input  logic                  a_m_ready,
    output logic [NH_WIDTH-1:0]   a_m_nexthop,
    output logic [ADDR_WIDTH-1:0] a_m_dest,
    output logic [15:0]           a_lookups,
    input  logic                  b_s_valid,
    output logic                  b_s_ready,
    input  logic [ADDR_WIDTH-1:0] b_s_dest,
    output logic [ADDR_WIDTH-1:0] b_tbl_dest,
    input  logic [NH_WIDTH-1:0]   b_tbl_nexthop,
    output logic                  b_m_valid,
    input  logic                  b_m_ready,
    output logic [NH_WIDTH-1:0]   b_m_nexthop,
    output logic [ADDR_WIDTH-1:0] b_m_dest,
    output logic [15:0]           b_lookups
);

    route_lookup_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NH_WIDTH   (NH_WIDTH)
    ) u_port_a (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .config_done (config_done),
        .s_valid     (a_s_valid),
        .s_ready     (a_s_ready),
        .s_dest      (a_s_dest),
        .tbl_dest    (a_tbl_dest),
        .tbl_nexthop (a_tbl_nexthop),
        .m_valid     (a_m_valid),
        .m_ready     (a_m_ready),
        .m_nexthop   (a_m_nexthop),
        .m_dest      (a_m_dest),
        .lookups     (a_lookups)
    );

    route_lookup_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NH_WIDTH   (NH_WIDTH)
    ) u_port_b (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .config_done (config_done),
        .s_valid     (b_s_valid),
        .s_ready     (b_s_ready),
        .s_dest      (b_s_dest),
        .tbl_dest    (b_tbl_dest),
        .tbl_nexthop (b_tbl_nexthop),
        .m_valid     (b_m_valid),
        .m_ready     (b_m_ready),
        .m_nexthop   (b_m_nexthop),
        .m_dest      (b_m_dest),
        .lookups     (b_lookups)
    );

endmodule

// File: tb/tb_route_lookup_ctrl.sv
// Bench for route_lookup_ctrl: a routing-table model feeds both ports, a
// scoreboard model tracks each port's lookup in flight, and a monitor
// compares every DUT output against it on the falling edge.

module tb_route_lookup_ctrl;

    localparam int AW = 8;
    localparam int NW = 9;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, enable, config_done;
    logic          a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic          b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [AW-1:0] a_s_dest, a_tbl_dest, a_m_dest;
    logic [AW-1:0] b_s_dest, b_tbl_dest, b_m_dest;
    logic [NW-1:0] a_tbl_nexthop, a_m_nexthop;
    logic [NW-1:0] b_tbl_nexthop, b_m_nexthop;
    logic [15:0]   a_lookups, b_lookups;

    route_lookup_ctrl #(.ADDR_WIDTH(AW), .NH_WIDTH(NW)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .config_done   (config_done),
        .a_s_valid     (a_s_valid),
        .a_s_ready     (a_s_ready),
        .a_s_dest      (a_s_dest),
        .a_tbl_dest    (a_tbl_dest),
        .a_tbl_nexthop (a_tbl_nexthop),
        .a_m_valid     (a_m_valid),
        .a_m_ready     (a_m_ready),
        .a_m_nexthop   (a_m_nexthop),
        .a_m_dest      (a_m_dest),
        .a_lookups     (a_lookups),
        .b_s_valid     (b_s_valid),
        .b_s_ready     (b_s_ready),
        .b_s_dest      (b_s_dest),
        .b_tbl_dest    (b_tbl_dest),
        .b_tbl_nexthop (b_tbl_nexthop),
        .b_m_valid     (b_m_valid),
        .b_m_ready     (b_m_ready),
        .b_m_nexthop   (b_m_nexthop),
        .b_m_dest      (b_m_dest),
        .b_lookups     (b_lookups)
    );

    // Routing table: one context, two registered read ports, gated by enable.
    logic [NW-1:0] mem [256];
    always @(posedge clock) begin
        if (enable) begin
            a_tbl_nexthop <= mem[a_tbl_dest];
            b_tbl_nexthop <= mem[b_tbl_dest];
        end
    end

    // Per-port views so model and monitor can loop over ports.
    logic [1:0]    sv_v, sr_v, mv_v, mr_v;
    logic [AW-1:0] sd_v [2];
    logic [AW-1:0] td_v [2];
    logic [AW-1:0] md_v [2];
    logic [NW-1:0] mn_v [2];
    logic [15:0]   lk_v [2];
    assign sv_v = {b_s_valid, a_s_valid};
    assign sr_v = {b_s_ready, a_s_ready};
    assign mv_v = {b_m_valid, a_m_valid};
    assign mr_v = {b_m_ready, a_m_ready};
    assign sd_v[0] = a_s_dest;     assign sd_v[1] = b_s_dest;
    assign td_v[0] = a_tbl_dest;   assign td_v[1] = b_tbl_dest;
    assign md_v[0] = a_m_dest;     assign md_v[1] = b_m_dest;
    assign mn_v[0] = a_m_nexthop;  assign mn_v[1] = b_m_nexthop;
    assign lk_v[0] = a_lookups;    assign lk_v[1] = b_lookups;

    // Reference model: one lookup in flight per port, result due two
    // enabled cycles after acceptance, counter bumps on each handshake.
    int            ecount = 0;
    bit            busy  [2];
    bit            fresh [2];
    int            stamp [2];
    logic [15:0]   cnt   [2];
    logic [15:0]   ofs   [2];
    bit            seen_reset = 1'b0;
    logic [AW-1:0] q_a [$];
    logic [AW-1:0] q_b [$];

    int n_chk  = 0;
    int n_pass = 0;

    always @(posedge clock) begin
        int  pre;
        bit  vld;
        if (reset) begin
            seen_reset = 1'b1;
            for (int p = 0; p < 2; p++) begin
                busy[p]  = 1'b0;
                fresh[p] = 1'b1;
                cnt[p]   = 16'd0;
            end
            q_a.delete();
            q_b.delete();
        end else if (enable) begin
            pre    = ecount;
            ecount = ecount + 1;
            for (int p = 0; p < 2; p++) begin
                vld = busy[p] && ((pre - stamp[p]) >= 2);
                if (vld && mr_v[p]) begin
                    busy[p] = 1'b0;
                    cnt[p]  = cnt[p] + 16'd1;
                    if (p == 0) void'(q_a.pop_front());
                    else        void'(q_b.pop_front());
                end else if (!busy[p] && config_done && sv_v[p]) begin
                    busy[p]  = 1'b1;
                    fresh[p] = 1'b0;
                    stamp[p] = ecount;
                    if (p == 0) q_a.push_back(sd_v[p]);
                    else        q_b.push_back(sd_v[p]);
                end
            end
        end
    end

    task automatic check(input string nm, input int p, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL port%s %s: got 0x%0h expected 0x%0h at %0t",
                      (p == 0) ? "A" : "B", nm, act, exp, $time);
    endtask

    // Monitor: compare all outputs against the model away from the active edge.
    always @(negedge clock) begin
        bit            exp_v;
        logic [AW-1:0] e;
        logic [15:0]   exp_cnt;
        if (seen_reset) begin
            for (int p = 0; p < 2; p++) begin
                exp_v   = busy[p] && ((ecount - stamp[p]) >= 2);
                exp_cnt = cnt[p] + ofs[p];
                check("s_ready", p, sr_v[p], !busy[p] && config_done && enable);
                check("m_valid", p, mv_v[p], exp_v);
                check("lookups", p, lk_v[p], exp_cnt);
                if (busy[p]) begin
                    e = (p == 0) ? q_a[0] : q_b[0];
                    check("tbl_dest", p, td_v[p], e);
                    check("m_dest", p, md_v[p], e);
                    if (exp_v) check("m_nexthop", p, mn_v[p], mem[e]);
                end else if (fresh[p]) begin
                    check("tbl_dest_rst", p, td_v[p], 0);
                    check("m_dest_rst", p, md_v[p], 0);
                    check("m_nexthop_rst", p, mn_v[p], 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_accept(input int p);
        int n = 0;
        do begin
            step();
            n++;
        end while (!busy[p] && n < 20);
        if (!busy[p]) begin
            $display("FAIL port%0d accept timeout", p);
            $fatal(1, "stopping: request never accepted");
        end
    endtask

    task automatic wait_idle(input int p);
        int n = 0;
        while (busy[p] && n < 60) begin
            step();
            n++;
        end
        if (busy[p]) begin
            $display("FAIL port%0d completion timeout", p);
            $fatal(1, "stopping: lookup never completed");
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; config_done = 1'b0;
        a_s_valid = 1'b0; b_s_valid = 1'b0; a_s_dest = '0; b_s_dest = '0;
        a_m_ready = 1'b0; b_m_ready = 1'b0;
        ofs[0] = 16'd0; ofs[1] = 16'd0;
        for (int i = 0; i < 256; i++) mem[i] = NW'($urandom_range(0, 511));
        mem[8'h2A] = 9'h105;
        mem[8'h01] = 9'h003;
        mem[8'hFF] = 9'h1F0;
        repeat (3) step();
        reset = 1'b0;

        // Table not configured: request must sit unaccepted for 10 cycles.
        a_s_valid = 1'b1; a_s_dest = 8'h2A;
        repeat (10) step();

        // First real lookup on A.
        a_m_ready = 1'b1; b_m_ready = 1'b1; config_done = 1'b1;
        wait_accept(0);
        a_s_valid = 1'b0;
        wait_idle(0);

        // Simultaneous independent requests on A and B.
        a_s_dest = 8'h01; b_s_dest = 8'hFF;
        a_s_valid = 1'b1; b_s_valid = 1'b1;
        wait_accept(0);
        a_s_valid = 1'b0; b_s_valid = 1'b0;
        wait_idle(0);
        wait_idle(1);

        // Stall for three cycles while A is in CAPTURE.
        a_s_dest = AW'($urandom); a_s_valid = 1'b1;
        wait_accept(0);
        a_s_valid = 1'b0;
        step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        wait_idle(0);

        // Back-pressure in HOLD with a second request waiting.
        a_m_ready = 1'b0;
        a_s_dest = AW'($urandom); a_s_valid = 1'b1;
        wait_accept(0);
        a_s_dest = AW'($urandom);
        repeat (7) step();
        a_m_ready = 1'b1;
        wait_idle(0);
        wait_accept(0);
        a_s_valid = 1'b0;
        wait_idle(0);

        // Randomized traffic on both ports.
        repeat (400) begin
            step();
            enable      = ($urandom_range(0, 7) != 0);
            config_done = ($urandom_range(0, 9) != 0);
            a_s_valid   = 1'($urandom);
            b_s_valid   = 1'($urandom);
            a_s_dest    = AW'($urandom);
            b_s_dest    = AW'($urandom);
            a_m_ready   = 1'($urandom);
            b_m_ready   = 1'($urandom);
        end
        enable = 1'b1; config_done = 1'b1;
        a_s_valid = 1'b0; b_s_valid = 1'b0;
        a_m_ready = 1'b1; b_m_ready = 1'b1;
        wait_idle(0);
        wait_idle(1);

        // Counter wrap: preload A's counter to 0xFFFF, then one more lookup.
        @(negedge clock);
        #2;
        force dut.u_port_a.lookup_cnt = 16'hFFFF;
        ofs[0] = 16'hFFFF - cnt[0];
        @(negedge clock);
        #2;
        release dut.u_port_a.lookup_cnt;
        step();
        a_s_dest = AW'($urandom); a_s_valid = 1'b1;
        wait_accept(0);
        a_s_valid = 1'b0;
        wait_idle(0);
        repeat (2) step();

        // Reset while A is in ISSUE discards the lookup.
        a_s_dest = AW'($urandom); a_s_valid = 1'b1;
        wait_accept(0);
        a_s_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ofs[0] = 16'd0;
        repeat (2) step();

        // Recovery after reset on both ports.
        a_s_dest = 8'h2A; b_s_dest = 8'h01;
        a_s_valid = 1'b1; b_s_valid = 1'b1;
        wait_accept(0);
        a_s_valid = 1'b0; b_s_valid = 1'b0;
        wait_idle(0);
        wait_idle(1);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
